fix_session_acceptor: RTL

- Acceptor (exchange-side) end of the FIX session layer. It is the counterpart to the initiator session FSM that sends logon, orders, heartbeats and logout.
- Consumes per-message strobes from the FIX decoder (type, MsgSeqNum, PossDupFlag) and decides the session-level reply.
- Queues reply type codes plus reference seq in a 4-entry FIFO. The downstream header/body encoder drains the FIFO over valid/ready.
- Owns inbound seq checking, outbound seq numbering, heartbeat generation and peer-liveness (TestRequest) supervision.

---
 rtl/fix_session_acceptor.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fix_session_acceptor.sv
// rtl/fix_session_acceptor.sv - FIX acceptor session layer; FIX_SEQ_GAP_RESEND_EN selects ResendRequest on a gap (else gap forces logout)
module fix_session_acceptor #(
    parameter int unsigned HB_CYCLES = 32'd10000000,
    parameter int unsigned SEQ_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept_en,
    input  logic             rx_valid,
    input  logic [7:0]       rx_msg_type,
    input  logic [SEQ_W-1:0] rx_seq_num,
    input  logic             rx_poss_dup,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_msg_type,
    output logic [SEQ_W-1:0] tx_ref_seq,
    output logic [SEQ_W-1:0] tx_seq_num,
    output logic             session_active,
    output logic             session_error,
    output logic             fifo_overflow
);

    localparam logic [7:0] T_HB    = 8'h30; // '0' Heartbeat
    localparam logic [7:0] T_TR    = 8'h31; // '1' TestRequest
    localparam logic [7:0] T_RR    = 8'h32; // '2' ResendRequest
    localparam logic [7:0] T_REJ   = 8'h33; // '3' Reject
    localparam logic [7:0] T_SR    = 8'h34; // '4' SequenceReset
    localparam logic [7:0] T_LO    = 8'h35; // '5' Logout
    localparam logic [7:0] T_ER    = 8'h38; // '8' ExecutionReport
    localparam logic [7:0] T_LOGON = 8'h41; // 'A'
    localparam logic [7:0] T_NOS   = 8'h44; // 'D'
    localparam logic [7:0] T_OCR   = 8'h46; // 'F'
    localparam logic [7:0] T_OCRR  = 8'h47; // 'G'

    localparam logic [31:0]      HB_TERM = HB_CYCLES;
    localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};
    localparam logic [SEQ_W-1:0] SEQ_TWO = SEQ_ONE + SEQ_ONE;
    localparam logic [SEQ_W-1:0] SEQ_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_TEST_PENDING,
        S_LOGOUT_WAIT
    } state_t;

    state_t           state;
    state_t           next_state;
    state_t           rx_state;
    logic [7:0]       q_type [4];
    logic [SEQ_W-1:0] q_ref  [4];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [2:0]       count;
    logic [SEQ_W-1:0] exp_seq;
    logic [SEQ_W-1:0] out_seq;
    logic [31:0]      tx_idle;
    logic [31:0]      rx_idle;
    logic             err_q;
    logic             ovf_q;

    logic             rx_enq;
    logic [7:0]       rx_type;
    logic [SEQ_W-1:0] rx_ref;
    logic             rx_adv;
    logic             rx_logon;
    logic             rx_fire;
    logic             tx_fire;
    logic             enq;
    logic             enq_ok;
    logic             deq;
    logic             flush;
    logic [7:0]       enq_type;
    logic [SEQ_W-1:0] enq_ref;

    assign tx_valid       = (count != 3'd0);
    assign tx_msg_type    = tx_valid ? q_type[rd_ptr] : 8'h00;
    assign tx_ref_seq     = tx_valid ? q_ref[rd_ptr] : '0;
    assign tx_seq_num     = out_seq;
    assign session_active = (state == S_ACTIVE) || (state == S_TEST_PENDING);
    assign session_error  = err_q;
    assign fifo_overflow  = ovf_q;

    // Decode the inbound message into the reply it earns and the state it leads to
    always_comb begin
        rx_enq   = 1'b0;
        rx_type  = 8'h00;
        rx_ref   = '0;
        rx_adv   = 1'b0;
        rx_logon = 1'b0;
        rx_state = state;
        if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (rx_msg_type == T_LOGON) begin
                        rx_enq = 1'b1;
                        if (accept_en && rx_seq_num == SEQ_ONE) begin
                            rx_type  = T_LOGON;
                            rx_logon = 1'b1;
                            rx_state = S_ACTIVE;
                        end else begin
                            rx_type = T_LO;
                        end
                    end
                end
                S_ACTIVE, S_TEST_PENDING: begin
                    rx_state = S_ACTIVE;
                    if (rx_seq_num == exp_seq) begin
                        rx_adv = 1'b1;
                        case (rx_msg_type)
                            T_HB: ;
                            T_TR: begin
                                rx_enq  = 1'b1;
                                rx_type = T_HB;
                            end
                            T_RR: begin
                                rx_enq  = 1'b1;
                                rx_type = T_SR;
                                rx_ref  = out_seq;
                            end
                            T_LO: begin
                                rx_enq   = 1'b1;
                                rx_type  = T_LO;
                                rx_state = S_IDLE;
                            end
                            T_NOS, T_OCR, T_OCRR: begin
                                rx_enq  = 1'b1;
                                rx_type = T_ER;
                                rx_ref  = rx_seq_num;
                            end
                            default: begin
                                rx_enq  = 1'b1;
                                rx_type = T_REJ;
                                rx_ref  = rx_seq_num;
                            end
                        endcase
                    end else if (rx_seq_num > exp_seq) begin
`ifdef FIX_SEQ_GAP_RESEND_EN
                        rx_enq  = 1'b1;
                        rx_type = T_RR;
                        rx_ref  = exp_seq;
`else
                        rx_enq   = 1'b1;
                        rx_type  = T_LO;
                        rx_state = S_LOGOUT_WAIT;
`endif
                    end else if (!rx_poss_dup) begin
                        rx_enq   = 1'b1;
                        rx_type  = T_LO;
                        rx_state = S_LOGOUT_WAIT;
                    end
                end
                S_LOGOUT_WAIT: begin
                    if (rx_msg_type == T_LO) rx_state = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    // Arbitrate rx reply, liveness probe and heartbeat into one enqueue; pick next state
    always_comb begin
        rx_fire  = !rx_valid && (state != S_IDLE) && (rx_idle == HB_TERM);
        tx_fire  = (state == S_ACTIVE) && (tx_idle == HB_TERM) && !rx_enq && !rx_fire;
        deq      = tx_valid && tx_ready;
        flush    = rx_fire && (state == S_TEST_PENDING);
        enq      = 1'b0;
        enq_type = 8'h00;
        enq_ref  = '0;
        if (rx_enq) begin
            enq      = 1'b1;
            enq_type = rx_type;
            enq_ref  = rx_ref;
        end else if (rx_fire && state == S_ACTIVE) begin
            enq      = 1'b1;
            enq_type = T_TR;
        end else if (tx_fire) begin
            enq      = 1'b1;
            enq_type = T_HB;
        end
        enq_ok     = enq && ((count != 3'd4) || deq);
        next_state = state;
        if (rx_valid) begin
            next_state = rx_state;
        end else if (rx_fire) begin
            next_state = (state == S_ACTIVE) ? S_TEST_PENDING : S_IDLE;
        end
    end

    // Session state, reply FIFO, sequence counters and idle timers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count   <= 3'd0;
            exp_seq <= SEQ_ONE;
            out_seq <= SEQ_ONE;
            tx_idle <= 32'd0;
            rx_idle <= 32'd0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state <= next_state;
            err_q <= 1'b0;

            if (flush) begin
                wr_ptr <= 2'd0;
                rd_ptr <= 2'd0;
                count  <= 3'd0;
                err_q  <= 1'b1;
            end else begin
                if (enq_ok) begin
                    q_type[wr_ptr] <= enq_type;
                    q_ref[wr_ptr]  <= enq_ref;
                    wr_ptr         <= wr_ptr + 2'd1;
                end
                if (deq) rd_ptr <= rd_ptr + 2'd1;
                if (enq_ok && !deq) count <= count + 3'd1;
                else if (!enq_ok && deq) count <= count - 3'd1;
                if (enq && !enq_ok) begin
                    ovf_q <= 1'b1;
                    err_q <= 1'b1;
                end
            end

            if (rx_logon) exp_seq <= SEQ_TWO;
            else if (rx_adv) exp_seq <= (exp_seq == SEQ_MAX) ? SEQ_ONE : exp_seq + SEQ_ONE;

            if (rx_logon) out_seq <= SEQ_ONE;
            else if (deq) out_seq <= (out_seq == SEQ_MAX) ? SEQ_ONE : out_seq + SEQ_ONE;

            if (next_state == S_IDLE || rx_valid || rx_fire) rx_idle <= 32'd0;
            else if (rx_idle != HB_TERM) rx_idle <= rx_idle + 32'd1;

            if (next_state == S_IDLE || enq || deq) tx_idle <= 32'd0;
            else if (tx_idle != HB_TERM) tx_idle <= tx_idle + 32'd1;
        end
    end

endmodule
